ram_waitstate: RTL and testbench

- Parametrised successor to the simple byte-masked data RAM used behind the core's dmem port.
- Adds configurable depth and data width, a valid/ready request/response handshake, and a programmable wait-state count.
- Out-of-range accesses are flagged instead of silently aliasing.
- Use: next-generation core integration and stall-path verification, where the memory is no longer zero-latency.

---
 rtl/ram_waitstate.sv | 182 ++++++++++++++++++
 tb/tb_ram_waitstate.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_waitstate.sv
// ram_waitstate: word-addressed data RAM with byte write masks, a
// valid/ready request/response handshake and a fixed number of wait states
// between request accept and response.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (high only in IDLE)
//   req_op      0 = read, 1 = write
//   req_addr    word address
//   req_mask    byte write enables; bit i covers bits 8i+7:8i
//   req_wdata   write data
//   resp_valid  response available (high only in RESP)
//   resp_ready  consumer takes the response
//   resp_rdata  read data; 0 for writes and out-of-range accesses
//   resp_err    address was >= DEPTH
//   busy        high in any state other than IDLE
//   dbg_state   current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. The request fields are latched
// at the request transfer and the live req_* inputs are ignored until the
// block returns to IDLE. resp_rdata/resp_err are held stable while
// resp_valid is high and are cleared by the response transfer. A request
// is never accepted on the same edge as a response transfer.

module ram_waitstate #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16384,
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_mask,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int NB = DATA_WIDTH / 8;

    // Counter reload value: WAIT is held for WAIT_CYCLES cycles, the last
    // one being the cycle in which the counter reads zero.
    localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    // One extra bit so DEPTH == 2^ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic [7:0]            cnt;
    logic                  op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         mask_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Fields used by the commit. With zero wait states the commit happens on
    // the accept edge itself, so the live request must be used instead of
    // the (not yet loaded) latched copy.
    logic                  commit;
    logic                  acc_op;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [NB-1:0]         acc_mask;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  in_range;
    logic                  mem_we;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        commit     = 1'b0;
        acc_op     = op_q;
        acc_addr   = addr_q;
        acc_mask   = mask_q;
        acc_wdata  = wdata_q;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = ST_RESP;
                        commit     = 1'b1;
                        acc_op     = req_op;
                        acc_addr   = req_addr;
                        acc_mask   = req_mask;
                        acc_wdata  = req_wdata;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 8'd0) begin
                    next_state = ST_RESP;
                    commit     = 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_LIM);

    // Gated by rst so nothing reaches the array while reset is held.
    assign mem_we = commit && rst && acc_op && in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req_valid) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                mask_q  <= req_mask;
                wdata_q <= req_wdata;
                cnt     <= WAIT_LOAD;
            end else if (state == ST_WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit) begin
                err_q   <= !in_range;
                rdata_q <= (in_range && !acc_op) ? mem[acc_addr] : '0;
            end else if (state == ST_RESP && resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_ram_waitstate.sv
// Directed bench for ram_waitstate. Four instances share the request data
// inputs and resp_ready; each has its own rst and req_valid:
//   0: DEPTH=16384, WAIT_CYCLES=2
//   1: DEPTH=1000,  WAIT_CYCLES=2
//   2: DEPTH=64,    WAIT_CYCLES=0
//   3: DEPTH=64,    WAIT_CYCLES=4
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_ram_waitstate;

    logic        clk;
    logic        req_op;
    logic [13:0] req_addr;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rst_v        [4];
    logic        req_valid_v  [4];
    logic        req_ready_v  [4];
    logic        resp_valid_v [4];
    logic [31:0] resp_rdata_v [4];
    logic        resp_err_v   [4];
    logic        busy_v       [4];
    logic [1:0]  dbg_state_v  [4];

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT instances ----------------
    ram_waitstate #(.DATA_WIDTH(32), .DEPTH(16384), .ADDR_WIDTH(14), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_op(req_op), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_v[0]),
        .resp_err(resp_err_v[0]), .busy(busy_v[0]), .dbg_state(dbg_state_v[0]));

    ram_waitstate #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(14), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_op(req_op), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_v[1]),
        .resp_err(resp_err_v[1]), .busy(busy_v[1]), .dbg_state(dbg_state_v[1]));

    ram_waitstate #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(14), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_op(req_op), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_v[2]),
        .resp_err(resp_err_v[2]), .busy(busy_v[2]), .dbg_state(dbg_state_v[2]));

    ram_waitstate #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(14), .WAIT_CYCLES(4)) u_dut3 (
        .clk(clk), .rst(rst_v[3]), .req_valid(req_valid_v[3]), .req_ready(req_ready_v[3]),
        .req_op(req_op), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[3]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_v[3]),
        .resp_err(resp_err_v[3]), .busy(busy_v[3]), .dbg_state(dbg_state_v[3]));

    // ---------------- driver ----------------
    // One full transaction on instance idx. Starts and ends just after a
    // falling edge. lat is the number of rising edges from the accept edge
    // (counted as 1) up to and including the edge that raised resp_valid;
    // 0 means resp_valid never came within the budget.
    task automatic do_txn(input int idx, input logic op, input logic [13:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        req_op           = op;
        req_addr         = addr;
        req_mask         = mask;
        req_wdata        = wdata;
        resp_ready       = 1'b0;
        req_valid_v[idx] = 1'b1;
        @(negedge clk);
        req_valid_v[idx] = 1'b0;
        n = 1;
        while (!resp_valid_v[idx] && n < 64) begin
            @(negedge clk);
            n++;
        end
        lat   = resp_valid_v[idx] ? n : 0;
        rdata = resp_rdata_v[idx];
        err   = resp_err_v[idx];
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (req_ready_v[i] !== 1'b1) begin bad++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", i, req_ready_v[i]); end
            total++; if (resp_valid_v[i] !== 1'b0) begin bad++; $display("FAIL reset_resp_valid[%0d] got=%b exp=0", i, resp_valid_v[i]); end
            total++; if (resp_rdata_v[i] !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata[%0d] got=%h exp=0", i, resp_rdata_v[i]); end
            total++; if (resp_err_v[i] !== 1'b0) begin bad++; $display("FAIL reset_resp_err[%0d] got=%b exp=0", i, resp_err_v[i]); end
            total++; if (busy_v[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_v[i]); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 1'b1, 14'h400, 4'b1111, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", er); end
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL wr_idle_after got=%b exp=0", busy_v[0]); end
        do_txn(0, 1'b0, 14'h400, 4'b0000, 32'h0, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 1'b1, 14'd5, 4'b1111, 32'h12345678, rd, er, lat);
        do_txn(0, 1'b1, 14'd5, 4'b0100, 32'h00AB0000, rd, er, lat);
        do_txn(0, 1'b0, 14'd5, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h12AB5678) begin bad++; $display("FAIL mask_byte2 got=%h exp=12ab5678", rd); end
        do_txn(0, 1'b1, 14'd5, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL mask_zero_err got=%b exp=0", er); end
        total++; if (lat !== 3) begin bad++; $display("FAIL mask_zero_latency got=%0d exp=3", lat); end
        do_txn(0, 1'b0, 14'd5, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h12AB5678) begin bad++; $display("FAIL mask_zero_unchanged got=%h exp=12ab5678", rd); end
        do_txn(0, 1'b1, 14'd5, 4'b1001, 32'hA1B2C3D4, rd, er, lat);
        do_txn(0, 1'b0, 14'd5, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hA1AB56D4) begin bad++; $display("FAIL mask_bytes03 got=%h exp=a1ab56d4", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        do_txn(1, 1'b1, 14'd999, 4'b1111, 32'h55AA33CC, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL oor_last_valid_err got=%b exp=0", er); end
        do_txn(1, 1'b0, 14'd1000, 4'b0000, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_rd1000_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd1000_data got=%h exp=0", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL oor_rd1000_latency got=%0d exp=3", lat); end
        do_txn(1, 1'b1, 14'd1023, 4'b1111, 32'hFFFFFFFF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_wr1023_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_wr1023_data got=%h exp=0", rd); end
        total++; if (resp_err_v[1] !== 1'b0) begin bad++; $display("FAIL oor_err_cleared got=%b exp=0", resp_err_v[1]); end
        do_txn(1, 1'b0, 14'd999, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h55AA33CC) begin bad++; $display("FAIL oor_rd999_data got=%h exp=55aa33cc", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL oor_rd999_err got=%b exp=0", er); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat;
        do_txn(2, 1'b1, 14'd3, 4'b1111, 32'h0BADC0DE, rd, er, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL zw_wr_latency got=%0d exp=1", lat); end
        req_op = 1'b0; req_addr = 14'd3; resp_ready = 1'b0; req_valid_v[2] = 1'b1;
        @(negedge clk);
        total++; if (req_ready_v[2] !== 1'b0) begin bad++; $display("FAIL zw_req_ready got=%b exp=0", req_ready_v[2]); end
        total++; if (resp_valid_v[2] !== 1'b1) begin bad++; $display("FAIL zw_resp_valid got=%b exp=1", resp_valid_v[2]); end
        total++; if (resp_rdata_v[2] !== 32'h0BADC0DE) begin bad++; $display("FAIL zw_rdata got=%h exp=0badc0de", resp_rdata_v[2]); end
        // Keep a different request pending; it must not be taken.
        req_op = 1'b1; req_addr = 14'd3; req_mask = 4'b1111; req_wdata = 32'h77777777;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (resp_valid_v[2] !== 1'b1) begin bad++; $display("FAIL zw_hold_valid[%0d] got=%b exp=1", k, resp_valid_v[2]); end
            total++; if (resp_rdata_v[2] !== 32'h0BADC0DE) begin bad++; $display("FAIL zw_hold_rdata[%0d] got=%h exp=0badc0de", k, resp_rdata_v[2]); end
            total++; if (req_ready_v[2] !== 1'b0) begin bad++; $display("FAIL zw_hold_ready[%0d] got=%b exp=0", k, req_ready_v[2]); end
        end
        req_valid_v[2] = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++; if (busy_v[2] !== 1'b0) begin bad++; $display("FAIL zw_idle_busy got=%b exp=0", busy_v[2]); end
        total++; if (resp_valid_v[2] !== 1'b0) begin bad++; $display("FAIL zw_idle_valid got=%b exp=0", resp_valid_v[2]); end
        total++; if (resp_rdata_v[2] !== 32'h0) begin bad++; $display("FAIL zw_idle_rdata got=%h exp=0", resp_rdata_v[2]); end
        total++; if (req_ready_v[2] !== 1'b1) begin bad++; $display("FAIL zw_idle_ready got=%b exp=1", req_ready_v[2]); end
        do_txn(2, 1'b0, 14'd3, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0BADC0DE) begin bad++; $display("FAIL zw_no_stray_write got=%h exp=0badc0de", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        do_txn(3, 1'b1, 14'd7, 4'b1111, 32'h0, rd, er, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL rm_latency got=%0d exp=5", lat); end
        req_op = 1'b1; req_addr = 14'd7; req_mask = 4'b1111; req_wdata = 32'hCAFEF00D;
        req_valid_v[3] = 1'b1;
        @(negedge clk);
        req_valid_v[3] = 1'b0;
        total++; if (busy_v[3] !== 1'b1) begin bad++; $display("FAIL rm_busy_in_wait got=%b exp=1", busy_v[3]); end
        @(negedge clk);
        @(negedge clk);
        rst_v[3] = 1'b0;
        #1;
        total++; if (req_ready_v[3] !== 1'b1) begin bad++; $display("FAIL rm_req_ready got=%b exp=1", req_ready_v[3]); end
        total++; if (resp_valid_v[3] !== 1'b0) begin bad++; $display("FAIL rm_resp_valid got=%b exp=0", resp_valid_v[3]); end
        total++; if (busy_v[3] !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy_v[3]); end
        total++; if (dbg_state_v[3] !== 2'd0) begin bad++; $display("FAIL rm_state got=%0d exp=0", dbg_state_v[3]); end
        @(negedge clk);
        @(negedge clk);
        rst_v[3] = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (resp_valid_v[3] !== 1'b0) begin bad++; $display("FAIL rm_no_late_resp got=%b exp=0", resp_valid_v[3]); end
        do_txn(3, 1'b0, 14'd7, 4'b0000, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rm_mem_unchanged got=%h exp=0", rd); end
        total++; if (lat !== 5) begin bad++; $display("FAIL rm_read_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; int n;
        do_txn(0, 1'b1, 14'h010, 4'b1111, 32'h11111111, rd, er, lat);
        do_txn(0, 1'b1, 14'h020, 4'b1111, 32'h22222222, rd, er, lat);
        req_op = 1'b0; req_addr = 14'h010; resp_ready = 1'b0; req_valid_v[0] = 1'b1;
        @(negedge clk);
        req_addr = 14'h020;
        total++; if (req_ready_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_wait got=%b exp=0", req_ready_v[0]); end
        n = 1;
        while (!resp_valid_v[0] && n < 64) begin @(negedge clk); n++; end
        total++; if (n !== 3 || resp_valid_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=3", n); end
        total++; if (resp_rdata_v[0] !== 32'h11111111) begin bad++; $display("FAIL b2b_first_data got=%h exp=11111111", resp_rdata_v[0]); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_idle_after_hs got=%b exp=0", busy_v[0]); end
        total++; if (req_ready_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_hs got=%b exp=1", req_ready_v[0]); end
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy_v[0]); end
        n = 1;
        while (!resp_valid_v[0] && n < 64) begin @(negedge clk); n++; end
        total++; if (n !== 3 || resp_valid_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=3", n); end
        total++; if (resp_rdata_v[0] !== 32'h22222222) begin bad++; $display("FAIL b2b_second_data got=%h exp=22222222", resp_rdata_v[0]); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_final_idle got=%b exp=0", busy_v[0]); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        req_op = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b0;
            req_valid_v[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        test_reset();
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
        @(negedge clk);
        test_write_read();
        test_byte_mask();
        test_out_of_range();
        test_zero_wait();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
